alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU. Width is configurable, and the opcode field widens to 4 bits to add carry-chained arithmetic, shifts/rotates and a multi-cycle shift-add multiply.
- Result and NZVC flags are registered. Operations use a start/busy/done handshake so the CPU control unit can stall on long operations.
- The carry flag is held internally and feeds ADC/SBC, which supports multi-word arithmetic.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4 to 32.
- CNT_W, $clog2(WIDTH+1), multiply cycle-counter width; derived, do not override.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  launches the operation on A, B, ALU_Sel; sampled only when busy=0.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- ALU_Sel  in  4  opcode.
- flag_we  in  1  when 1 with start, the NZVC register is updated on completion; when 0, flags are held.
- Result  out  WIDTH  registered result.
- NZVC  out  4  registered flags: [3]=N, [2]=Z, [1]=V, [0]=C.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse; Result/NZVC are valid that cycle.

Behaviour:
- Reset (synchronous, active-high, dominates every other input): Result=0, NZVC=0, busy=0, done=0, FSM in IDLE, multiplier state cleared. Asserting reset mid-multiply aborts the multiply with no done pulse.
- FSM states: IDLE and MUL.
  - IDLE: start with any non-MUL op at edge t → Result and flags registered at edge t+1, done=1 for that one cycle.
  - IDLE: start with MUL at t → MUL state; busy=1 for cycles t+1 through t+WIDTH. At edge t+WIDTH+1: busy=0, done=1, return to IDLE.
- start while busy=1 is ignored; no queuing.
- Back-to-back single-cycle ops are allowed: start on consecutive cycles yields done on consecutive cycles.
- Opcodes and computation (Cin is the stored NZVC[0] at the edge where start is sampled):
  - 0 ADD: {C,R}=A+B.
  - 1 INC: {C,R}=A+1.
  - 2 SUB: {C,R}=A−B.
  - 3 DEC: {C,R}=A−1.
  - 4 AND, 5 OR, 6 XOR: bitwise on A, B.
  - 7 NOT: R=~A.
  - 8 ADC: {C,R}=A+B+Cin.
  - 9 SBC: {C,R}=A−B−Cin.
  - 10 SHL: R=A<<1.
  - 11 SHR (logical): R=A>>1.
  - 12 ASR: R=A>>>1, sign bit preserved.
  - 13 ROL: R={A[W-2:0],A[W-1]}.
  - 14 ROR: R={A[0],A[W-1:1]}.
  - 15 MUL: shift-add, one partial product per cycle, full 2*WIDTH product held internally; Result = low WIDTH bits.
- Carry rule for subtract ops: C is bit WIDTH of the (WIDTH+1)-bit subtraction, i.e. C=1 means unsigned borrow.
- Flag rules:
  - N=R[MSB] and Z=(R==0) for all ops.
  - V, add-type ops (ADD, ADC, INC): V=1 when both operand signs are equal and the result sign differs. For INC the second operand is +1.
  - V, sub-type ops (SUB, SBC, DEC): V=1 when operand signs differ and the result sign differs from A. For DEC the second operand is 1.
  - Logic ops: V=0, C=0.
  - Shifts and rotates: C = bit shifted out (A[MSB] for SHL/ROL, A[0] for SHR/ASR/ROR), V=0.
  - MUL: C = V = (high half of the product != 0).
- flag_we=0: Result updates and done pulses, but NZVC holds. Cin for a later ADC/SBC is the held value.
- Result holds its last value between operations. Inputs are captured at start; changes while busy have no effect.

Decomposition:
- Package alu_pkg:
  - 4-bit opcode localparams OP_ADD through OP_MUL.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0.
  - FSM state encoding.
- Sub-module alu_mul_seq:
  - Parametrised by WIDTH; interface load/A/B in, busy/done/product[2*WIDTH-1:0] out.
  - alu_seq instantiates it and muxes its product into Result.

Test Plan (WIDTH=8):
- Reset, then ADD A=0x7F B=0x01 flag_we=1 → next cycle done=1, Result=0x80, NZVC=1010.
- SUB A=0x00 B=0x01 → Result=0xFF, NZVC=1001. Then ADC A=0xFF B=0x00 (Cin=1) → Result=0x00, NZVC=0101.
- ROR A=0x01 → Result=0x80, NZVC=1001. Next, ASR A=0x80 with flag_we=0 → Result=0xC0, NZVC stays 1001.
- MUL A=0x10 B=0x10 at cycle t → busy=1 for cycles t+1 through t+8; done at t+9 with Result=0x00, NZVC=0111. MUL 0x0F×0x03 → Result=0x2D, NZVC=0000.
- start ADD asserted during a MUL's busy window → ignored; the MUL completes unchanged and exactly one done pulse occurs.
- reset asserted at cycle t+4 of a MUL → next cycle busy=0, done=0, Result=0x00, NZVC=0000; a fresh INC A=0xFF afterwards → Result=0x00, NZVC=0101.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the sequential ALU.
// No logic; constants only.
// Imported by alu_seq and alu_mul_seq.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_INC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_DEC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_SBC = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;
  localparam logic [3:0] OP_ASR = 4'd12;
  localparam logic [3:0] OP_ROL = 4'd13;
  localparam logic [3:0] OP_ROR = 4'd14;
  localparam logic [3:0] OP_MUL = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, full 2*WIDTH product.
// Latency: bit 0 folded in on load, final product ready with done WIDTH-1 cycles later.
// No backpressure: load while busy restarts the multiply; caller must avoid it.
module alu_mul_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  // Load folds in the first partial product, then one multiplier bit per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        mcand  <= {{(WIDTH-1){1'b0}}, A, 1'b0};
        mplier <= {1'b0, B[WIDTH-1:1]};
        acc    <= B[0] ? {{WIDTH{1'b0}}, A} : '0;
        cnt    <= CNT_INIT;
        busy   <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
        if (cnt == CNT_LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with NZVC flags, carry-chained ADC/SBC, shifts/rotates and sequential MUL.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL (busy for WIDTH cycles).
// Backpressure: start is ignored while busy; no queuing.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  input  logic             flag_we,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       NZVC,
  output logic             busy,
  output logic             done
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic               mul_load, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic               alu_upd, mul_fin, mul_fwe_q;

  logic [WIDTH:0]     ext, cin_ext;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c, alu_v;
  logic [3:0]         nzvc_alu, nzvc_mul;
  logic               mul_hi_nz;

  alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .load    (mul_load),
    .A       (A),
    .B       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign cin_ext = {{WIDTH{1'b0}}, NZVC[FLAG_C]};

  // Single-cycle datapath: result, carry and overflow for every non-MUL opcode.
  always_comb begin
    ext   = '0;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (ALU_Sel)
      OP_ADD: begin
        ext   = {1'b0, A} + {1'b0, B};
        alu_r = ext[MSB:0];
        alu_c = ext[WIDTH];
        alu_v = (A[MSB] == B[MSB]) && (alu_r[MSB] != A[MSB]);
      end
      OP_ADC: begin
        ext   = {1'b0, A} + {1'b0, B} + cin_ext;
        alu_r = ext[MSB:0];
        alu_c = ext[WIDTH];
        alu_v = (A[MSB] == B[MSB]) && (alu_r[MSB] != A[MSB]);
      end
      OP_INC: begin
        ext   = {1'b0, A} + ONE_EXT;
        alu_r = ext[MSB:0];
        alu_c = ext[WIDTH];
        alu_v = !A[MSB] && alu_r[MSB];
      end
      OP_SUB: begin
        ext   = {1'b0, A} - {1'b0, B};
        alu_r = ext[MSB:0];
        alu_c = ext[WIDTH];
        alu_v = (A[MSB] != B[MSB]) && (alu_r[MSB] != A[MSB]);
      end
      OP_SBC: begin
        ext   = {1'b0, A} - {1'b0, B} - cin_ext;
        alu_r = ext[MSB:0];
        alu_c = ext[WIDTH];
        alu_v = (A[MSB] != B[MSB]) && (alu_r[MSB] != A[MSB]);
      end
      OP_DEC: begin
        ext   = {1'b0, A} - ONE_EXT;
        alu_r = ext[MSB:0];
        alu_c = ext[WIDTH];
        alu_v = A[MSB] && !alu_r[MSB];
      end
      OP_AND: alu_r = A & B;
      OP_OR:  alu_r = A | B;
      OP_XOR: alu_r = A ^ B;
      OP_NOT: alu_r = ~A;
      OP_SHL: begin
        alu_r = {A[MSB-1:0], 1'b0};
        alu_c = A[MSB];
      end
      OP_SHR: begin
        alu_r = {1'b0, A[MSB:1]};
        alu_c = A[0];
      end
      OP_ASR: begin
        alu_r = {A[MSB], A[MSB:1]};
        alu_c = A[0];
      end
      OP_ROL: begin
        alu_r = {A[MSB-1:0], A[MSB]};
        alu_c = A[MSB];
      end
      OP_ROR: begin
        alu_r = {A[0], A[MSB:1]};
        alu_c = A[0];
      end
      default: ;
    endcase
  end

  assign nzvc_alu  = {alu_r[MSB], (alu_r == '0), alu_v, alu_c};
  assign mul_hi_nz = (mul_product[2*WIDTH-1:WIDTH] != '0);
  assign nzvc_mul  = {mul_product[MSB], (mul_product[MSB:0] == '0), mul_hi_nz, mul_hi_nz};

  // Control state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle control strobes; start only counts in IDLE.
  always_comb begin
    state_d  = state_q;
    mul_load = 1'b0;
    alu_upd  = 1'b0;
    mul_fin  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (ALU_Sel == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = ST_MUL;
          end else begin
            alu_upd = 1'b1;
          end
        end
      end
      ST_MUL: begin
        // The multiplier drops busy in the same cycle it pulses done.
        if (mul_done && !mul_busy) begin
          mul_fin = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_MUL);

  // Output registers: result, flags (gated by flag_we captured at start) and done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      Result    <= '0;
      NZVC      <= '0;
      done      <= 1'b0;
      mul_fwe_q <= 1'b0;
    end else begin
      done <= alu_upd | mul_fin;
      if (mul_load) begin
        mul_fwe_q <= flag_we;
      end
      if (alu_upd) begin
        Result <= alu_r;
        if (flag_we) begin
          NZVC <= nzvc_alu;
        end
      end
      if (mul_fin) begin
        Result <= mul_product[MSB:0];
        if (mul_fwe_q) begin
          NZVC <= nzvc_mul;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: table of back-to-back single-cycle ops
// plus hand-written MUL, start-while-busy and reset-mid-multiply sequences.
// Inputs change just after the rising edge; outputs are sampled on the falling edge.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A, B;
  logic [3:0]   ALU_Sel;
  logic         flag_we;
  logic [W-1:0] Result;
  logic [3:0]   NZVC;
  logic         busy, done;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .A       (A),
    .B       (B),
    .ALU_Sel (ALU_Sel),
    .flag_we (flag_we),
    .Result  (Result),
    .NZVC    (NZVC),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         fwe;
    logic [W-1:0] r;
    logic [3:0]   f;
  } vec_t;

  localparam int NV = 19;
  vec_t vt[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic fwe);
    start   = 1'b1;
    ALU_Sel = sel;
    A       = a;
    B       = b;
    flag_we = fwe;
  endtask

  // Launch a MUL, optionally poke an ADD mid-busy, and check the whole handshake.
  task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic fwe, input logic inject,
                         input logic [W-1:0] exp_r, input logic [3:0] exp_f);
    int busy_bad;
    int done_cnt;
    busy_bad = 0;
    done_cnt = 0;
    @(negedge clock);
    drive(OP_MUL, a, b, fwe);
    @(posedge clock);
    #1 start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      @(negedge clock);
      if (busy !== 1'b1) busy_bad++;
      if (done !== 1'b0) done_cnt++;
      if (inject && k == 2) drive(OP_ADD, 8'h01, 8'h01, 1'b1);
      if (inject && k == 4) start = 1'b0;
    end
    chk({name, " busy cycles"}, busy_bad, 0);
    chk({name, " early done"}, done_cnt, 0);
    @(negedge clock);
    chk({name, " busy end"}, busy, 1'b0);
    chk({name, " done"}, done, 1'b1);
    chk({name, " result"}, Result, exp_r);
    chk({name, " nzvc"}, NZVC, exp_f);
    @(negedge clock);
    chk({name, " done single"}, done, 1'b0);
    chk({name, " result hold"}, Result, exp_r);
  endtask

  initial begin
    vt[0]  = '{OP_ADD, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b1010};
    vt[1]  = '{OP_SUB, 8'h00, 8'h01, 1'b1, 8'hFF, 4'b1001};
    vt[2]  = '{OP_ADC, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b0101};
    vt[3]  = '{OP_ROR, 8'h01, 8'h00, 1'b1, 8'h80, 4'b1001};
    vt[4]  = '{OP_ASR, 8'h80, 8'h00, 1'b0, 8'hC0, 4'b1001};
    vt[5]  = '{OP_SBC, 8'h05, 8'h02, 1'b1, 8'h02, 4'b0000};
    vt[6]  = '{OP_AND, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000};
    vt[7]  = '{OP_OR,  8'h00, 8'h00, 1'b1, 8'h00, 4'b0100};
    vt[8]  = '{OP_XOR, 8'hFF, 8'h0F, 1'b1, 8'hF0, 4'b1000};
    vt[9]  = '{OP_NOT, 8'h0F, 8'h00, 1'b1, 8'hF0, 4'b1000};
    vt[10] = '{OP_INC, 8'h7F, 8'h00, 1'b1, 8'h80, 4'b1010};
    vt[11] = '{OP_DEC, 8'h80, 8'h00, 1'b1, 8'h7F, 4'b0010};
    vt[12] = '{OP_SHL, 8'h81, 8'h00, 1'b1, 8'h02, 4'b0001};
    vt[13] = '{OP_SHR, 8'h81, 8'h00, 1'b1, 8'h40, 4'b0001};
    vt[14] = '{OP_ROL, 8'h80, 8'h00, 1'b1, 8'h01, 4'b0001};
    vt[15] = '{OP_SUB, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b0010};
    vt[16] = '{OP_ADC, 8'h01, 8'h01, 1'b1, 8'h02, 4'b0000};
    vt[17] = '{OP_SBC, 8'h00, 8'h00, 1'b1, 8'h00, 4'b0100};
    vt[18] = '{OP_DEC, 8'h00, 8'h00, 1'b1, 8'hFF, 4'b1001};

    reset   = 1'b1;
    start   = 1'b0;
    A       = '0;
    B       = '0;
    ALU_Sel = OP_ADD;
    flag_we = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset result", Result, 8'h00);
    chk("reset nzvc", NZVC, 4'b0000);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);

    // Back-to-back single-cycle ops: start held high, one done per cycle.
    drive(vt[0].sel, vt[0].a, vt[0].b, vt[0].fwe);
    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      chk($sformatf("vec%0d done", i), done, 1'b1);
      chk($sformatf("vec%0d result", i), Result, vt[i].r);
      chk($sformatf("vec%0d nzvc", i), NZVC, vt[i].f);
      if (i + 1 < NV) drive(vt[i+1].sel, vt[i+1].a, vt[i+1].b, vt[i+1].fwe);
      else start = 1'b0;
    end
    @(negedge clock);
    chk("idle done", done, 1'b0);
    chk("idle result hold", Result, 8'hFF);

    run_mul("mul 10x10 inject", 8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 4'b0111);
    run_mul("mul 0Fx03", 8'h0F, 8'h03, 1'b1, 1'b0, 8'h2D, 4'b0000);

    // Set nonzero flags, then MUL with flag_we=0 must leave them alone.
    @(negedge clock);
    drive(OP_ADD, 8'h7F, 8'h01, 1'b1);
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    chk("add pre nzvc", NZVC, 4'b1010);
    run_mul("mul FFxFF nofl", 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h01, 4'b1010);

    // Reset in the middle of a multiply aborts it with no done pulse.
    begin
      int done_cnt;
      done_cnt = 0;
      @(negedge clock);
      drive(OP_MUL, 8'h0F, 8'h03, 1'b1);
      @(posedge clock);
      #1 start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("abort busy", busy, 1'b0);
      chk("abort done", done, 1'b0);
      chk("abort result", Result, 8'h00);
      chk("abort nzvc", NZVC, 4'b0000);
      for (int k = 0; k < 2 * W; k++) begin
        @(negedge clock);
        if (done !== 1'b0 || busy !== 1'b0) done_cnt++;
      end
      chk("abort quiet", done_cnt, 0);
    end

    drive(OP_INC, 8'hFF, 8'h00, 1'b1);
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    chk("inc done", done, 1'b1);
    chk("inc result", Result, 8'h00);
    chk("inc nzvc", NZVC, 4'b0101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
